led_sweep_monitor: RTL and testbench
====================================

# led_sweep_monitor

Downstream consumer of the 18-bit bouncing-LED shift register. Samples the LED vector every clock, checks it is one-hot, encodes the lit position, and tracks sweep direction. Counts end-of-travel bounces in two-digit BCD for the seven-segment display. Flags a sticky error when the vector stops being one-hot.

## Interface
Parameters:
- WIDTH, 18: width of the LED vector; legal range 2..32.
- ERR_HOLD, 4: number of consecutive non-one-hot samples in TRACK that sets `err`; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge; same clock that drives the shift register.
- R  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear, active-high.
- qin  in  WIDTH  LED vector from the shift register.
- pos  out  $clog2(WIDTH)  binary index of the lit bit.
- valid  out  1  the sample behind `pos` was one-hot.
- dir  out  1  sweep direction; 1 = toward MSB, 0 = toward LSB.
- bounce  out  1  one-cycle pulse when an end position (bit 0 or bit WIDTH-1) is reached.
- bcount  out  8  bounce count, two BCD digits, range 00..99.
- err  out  1  sticky error flag.
- HEX0  out  7  ones digit of `bcount`; active-low segments, bit order gfedcba.
- HEX1  out  7  tens digit of `bcount`; same encoding as HEX0.

## Operation
- Stage 1: register `s1 <= qin`.
- Stage 2: decode `s1`:
  - one-hot → `valid=1` and `pos` = index of the set bit.
  - otherwise → `valid=0`; `pos` holds its last value.
- `prev_pos` holds the last valid position.
- A step is a valid sample with |pos − prev_pos| == 1.
- State machine:
  - INIT (reset/clr state):
    - A valid sample loads `prev_pos` and moves to TRACK.
    - No bounce and no direction change in INIT.
  - TRACK:
    - On a step: `dir = (pos > prev_pos)`; `prev_pos = pos`.
    - If a step lands on 0 or WIDTH-1: `bounce = 1` and `bcount` increments.
    - A valid non-adjacent jump updates `prev_pos` only.
    - A valid sample with unchanged position changes nothing.
    - Each invalid sample increments `inv_cnt`; any valid sample clears it.
    - When `inv_cnt` reaches ERR_HOLD: go to ERROR and set `err = 1`.
  - ERROR:
    - `pos` and `valid` keep updating.
    - `dir`, `bounce` and `bcount` are frozen.
    - Leaves only on `clr` or reset.
- BCD increment:
  - Ones digit 9 → 0 with a carry into the tens digit.
  - 99 → 00 wrap, no overflow flag.
- `clr`:
  - Sets `bcount = 00`, `err = 0`, `inv_cnt = 0`, `bounce = 0`; state goes to INIT.
  - `pos`, `valid` and `dir` are unaffected.
  - `clr` wins over a simultaneous bounce, so `bcount` ends at 00.
- Reset values: `pos = 0`, `valid = 0`, `dir = 0`, `bounce = 0`, `bcount = 8'h00`, `err = 0`, `s1 = 0`, state INIT. HEX0/HEX1 = 7'h40 ("0").

## Timing
- All outputs are registered.
- Latency from `qin` to `pos`/`valid`/`dir`/`bounce`/`bcount`: 2 rising edges.
- HEX0/HEX1 are a combinational decode of registered `bcount`, so they follow `bcount` with no extra cycle.
- `bounce` is high for exactly one cycle per qualifying step.
- `err` asserts on the same edge that the ERR_HOLD-th consecutive invalid sample reaches stage 2.
- Asserting `R` low clears all state immediately, with no clock edge needed, including mid-sweep.
- Releasing `R` takes effect at the next rising edge.

## Configuration
- Macro `LED_SWEEP_HEX_EN`.
  - Defined: HEX0/HEX1 decode `bcount` digits 0–9, active-low.
  - Undefined: the decoders are not built; HEX0/HEX1 are tied to 7'h7F (blank). All other behaviour is identical.
- The ports exist in both builds.

## Test plan
- Reset: hold `R` low with `qin` toggling → `pos=0`, `valid=0`, `dir=0`, `bounce=0`, `bcount=00`, `err=0`, HEX0/HEX1 = 7'h40 (macro defined).
- Sweep: drive `qin` = 1<<0, 1<<1 … 1<<17, then 1<<16 … 1<<0, one per cycle.
  - `pos` tracks 2 cycles later.
  - `dir` is 1 on the way up and falls on the first downward step.
  - `bounce` pulses once at arrival on 17 and once on return to 0.
  - Final `bcount = 8'h02`.
- Wrap: 99 bounces → `bcount = 8'h99` (HEX1 = HEX0 = 7'h10). One more bounce → `8'h00` (HEX = 7'h40).
- Error: `qin = 0` for 3 cycles, then one-hot → `err` stays 0. `qin = 18'h00003` for 4 cycles → `err = 1`. Further sweeps give no `bounce` and `bcount` is frozen. `clr` → `err = 0`, `bcount = 00`, state INIT.
- Simultaneous events: `clr` on the bounce cycle → `bcount = 00`, `bounce = 0`. A jump from 3 to 17 → no bounce.
- Async reset: drop `R` mid-cycle during a sweep → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/led_sweep_monitor.sv
// led_sweep_monitor: watches the bouncing-LED shift register output.
// Registers the LED vector, checks that it is one-hot, encodes the lit
// position, tracks sweep direction and counts end-of-travel bounces in
// two-digit BCD. A sticky err flag is raised after ERR_HOLD consecutive
// non-one-hot samples while tracking.
// Build option: define LED_SWEEP_HEX_EN to build the seven-segment decoders
// for HEX0/HEX1; otherwise both are tied to blank (7'h7F).
module led_sweep_monitor #(
  parameter int WIDTH    = 18,
  parameter int ERR_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         qin,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     valid,
  output logic                     dir,
  output logic                     bounce,
  output logic [7:0]               bcount,
  output logic                     err,
  output logic [6:0]               HEX0,
  output logic [6:0]               HEX1
);
  localparam int PW = $clog2(WIDTH);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             bounce_q, bounce_d;
  logic [7:0]       bcount_q, bcount_d;
  logic             err_q, err_d;
  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    prev_q, prev_d;
  logic [3:0]       inv_q, inv_d;

  logic             onehot;
  logic [PW-1:0]    idx;
  logic             step;
  logic             at_end;
  logic [7:0]       bcd_inc;

  // Stage-2 decode: one-hot check and index of the set bit.
  always_comb begin
    onehot = (s1_q != '0) && ((s1_q & (s1_q - 1'b1)) == '0);
    idx    = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s1_q[i]) idx = PW'(i);
  end

  // Adjacency test widened by one bit so WIDTH=32 cannot wrap 31+1 onto 0.
  always_comb begin
    step   = onehot && (({1'b0, idx} == {1'b0, prev_q} + 1'b1) ||
                        ({1'b0, prev_q} == {1'b0, idx} + 1'b1));
    at_end = (idx == '0) || (idx == PW'(WIDTH - 1));
  end

  // Two-digit BCD increment, 99 wraps to 00.
  always_comb begin
    bcd_inc = bcount_q;
    if (bcount_q[3:0] >= 4'd9) begin
      bcd_inc[3:0] = 4'd0;
      bcd_inc[7:4] = (bcount_q[7:4] >= 4'd9) ? 4'd0 : bcount_q[7:4] + 4'd1;
    end else begin
      bcd_inc[3:0] = bcount_q[3:0] + 4'd1;
    end
  end

  // Next-state logic: decode outputs, sweep FSM, bounce counting, error hold.
  always_comb begin
    s1_d     = qin;
    valid_d  = onehot;
    pos_d    = onehot ? idx : pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    bcount_d = bcount_q;
    err_d    = err_q;
    state_d  = state_q;
    prev_d   = prev_q;
    inv_d    = inv_q;
    if (clr) begin
      // clr outranks any bounce landing on the same edge
      bcount_d = 8'h00;
      err_d    = 1'b0;
      inv_d    = 4'd0;
      state_d  = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (onehot) begin
            prev_d  = idx;
            inv_d   = 4'd0;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (onehot) begin
            inv_d  = 4'd0;
            prev_d = idx;  // covers step, jump and no-move alike
            if (step) begin
              dir_d = (idx > prev_q);
              if (at_end) begin
                bounce_d = 1'b1;
                bcount_d = bcd_inc;
              end
            end
          end else if (inv_q + 4'd1 >= 4'(ERR_HOLD)) begin
            inv_d   = inv_q + 4'd1;
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            inv_d = inv_q + 4'd1;
          end
        end
        ST_ERROR: begin
          // frozen until clr or reset; pos/valid still follow the input
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State registers, cleared asynchronously by R.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      s1_q     <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
      bcount_q <= 8'h00;
      err_q    <= 1'b0;
      state_q  <= ST_INIT;
      prev_q   <= '0;
      inv_q    <= 4'd0;
    end else begin
      s1_q     <= s1_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      bcount_q <= bcount_d;
      err_q    <= err_d;
      state_q  <= state_d;
      prev_q   <= prev_d;
      inv_q    <= inv_d;
    end
  end

  assign pos    = pos_q;
  assign valid  = valid_q;
  assign dir    = dir_q;
  assign bounce = bounce_q;
  assign bcount = bcount_q;
  assign err    = err_q;

`ifdef LED_SWEEP_HEX_EN
  // Active-low gfedcba segments; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign HEX0 = seg7(bcount_q[3:0]);
  assign HEX1 = seg7(bcount_q[7:4]);
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
`endif

endmodule

// File: tb/tb_led_sweep_monitor.sv
// Bench for led_sweep_monitor: directed sweeps, wrap, error, clr and async
// reset steps followed by a random walk, all checked against an integer
// reference model of the sweep rules.
module tb_led_sweep_monitor;
  localparam int W  = 18;
  localparam int EH = 4;

  logic         clk = 1'b0;
  logic         R   = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] qin = '0;
  logic [4:0]   pos;
  logic         valid, dir, bounce, err;
  logic [7:0]   bcount;
  logic [6:0]   HEX0, HEX1;

  int vectors     = 0;
  int miscompares = 0;

  led_sweep_monitor #(.WIDTH(W), .ERR_HOLD(EH)) dut (
    .clk(clk), .R(R), .clr(clr), .qin(qin), .pos(pos), .valid(valid),
    .dir(dir), .bounce(bounce), .bcount(bcount), .err(err),
    .HEX0(HEX0), .HEX1(HEX1)
  );

  always #5 clk = ~clk;

  // reference model: bounce count kept as a plain integer 0..99
  int           m_pos, m_valid, m_dir, m_bounce, m_cnt, m_err;
  int           m_mode;  // 0 = waiting for first valid, 1 = tracking, 2 = error
  int           m_prev, m_inv;
  logic [W-1:0] m_s1;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h40; 1: seg = 7'h79; 2: seg = 7'h24; 3: seg = 7'h30;
      4: seg = 7'h19; 5: seg = 7'h12; 6: seg = 7'h02; 7: seg = 7'h78;
      8: seg = 7'h00; 9: seg = 7'h10; default: seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input int d);
`ifdef LED_SWEEP_HEX_EN
    exp_hex = seg(d);
`else
    exp_hex = 7'h7F;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_valid = 0; m_dir = 0; m_bounce = 0; m_cnt = 0; m_err = 0;
    m_mode = 0; m_prev = 0; m_inv = 0; m_s1 = '0;
  endtask

  task automatic model_step(input logic [W-1:0] s, input bit c);
    bit oh;
    int idx;
    int d;
    oh  = ($countones(s) == 1);
    idx = 0;
    for (int i = 0; i < W; i++) if (s[i]) idx = i;
    m_valid  = oh;
    if (oh) m_pos = idx;
    m_bounce = 0;
    if (c) begin
      m_cnt = 0; m_err = 0; m_inv = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (oh) begin m_prev = idx; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (oh) begin
        m_inv = 0;
        d = idx - m_prev;
        if (d == 1 || d == -1) begin
          m_dir = (idx > m_prev);
          if (idx == 0 || idx == W - 1) begin
            m_bounce = 1;
            m_cnt = (m_cnt + 1) % 100;
          end
        end
        m_prev = idx;
      end else begin
        m_inv++;
        if (m_inv == EH) begin m_mode = 2; m_err = 1; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pos",    32'(pos),    32'(m_pos));
    chk("valid",  32'(valid),  32'(m_valid));
    chk("dir",    32'(dir),    32'(m_dir));
    chk("bounce", 32'(bounce), 32'(m_bounce));
    chk("bcount", 32'(bcount), 32'({4'(m_cnt / 10), 4'(m_cnt % 10)}));
    chk("err",    32'(err),    32'(m_err));
    chk("HEX0",   32'(HEX0),   32'(exp_hex(m_cnt % 10)));
    chk("HEX1",   32'(HEX1),   32'(exp_hex(m_cnt / 10)));
  endtask

  task automatic tick(input logic [W-1:0] v, input bit c);
    qin = v;
    clr = c;
    @(posedge clk);
    model_step(m_s1, c);
    m_s1 = v;
    #1 check_all();
  endtask

  task automatic hot(input int k, input bit c = 0);
    logic [W-1:0] one;
    one = 1;
    tick(one << k, c);
  endtask

  task automatic sweep_up_down();
    for (int k = 0; k < W; k++) hot(k);
    for (int k = W - 2; k >= 0; k--) hot(k);
    hot(0);  // lets the final sample reach stage 2
  endtask

  initial begin
    int rp;
    int r;
    logic [W-1:0] rv;
    bit rc;

    // reset held with the input toggling
    model_reset();
    for (int i = 0; i < 4; i++) begin
      qin = W'($urandom);
      @(posedge clk);
      #1 check_all();
    end
    R = 1'b1;

    // full sweep up and back: two bounces
    sweep_up_down();
    chk("sweep_bcount", 32'(bcount), 32'h02);

    // wrap: bring count to 99, then one more
    for (int i = 0; i < 97; i++) begin hot(1); hot(0); end
    hot(0);
    chk("wrap99", 32'(bcount), 32'h99);
`ifdef LED_SWEEP_HEX_EN
    chk("hex99", 32'({HEX1, HEX0}), 32'({7'h10, 7'h10}));
`endif
    hot(1); hot(0); hot(0);
    chk("wrap00", 32'(bcount), 32'h00);

    // error: count 01, three invalid samples tolerated, four trip err
    hot(1); hot(0); hot(0);
    tick('0, 0); tick('0, 0); tick('0, 0);
    hot(1);
    tick(18'h00003, 0);
    chk("err_short", 32'(err), 32'h0);
    tick(18'h00003, 0); tick(18'h00003, 0); tick(18'h00003, 0);
    tick('0, 0);
    chk("err_set", 32'(err), 32'h1);
    sweep_up_down();
    chk("err_frozen", 32'(bcount), 32'h01);
    hot(0, 1);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_bcount", 32'(bcount), 32'h00);

    // clr on the edge where a bounce would land
    hot(2); hot(1); hot(0);
    hot(0, 1);
    chk("clr_bounce", 32'(bounce), 32'h0);
    chk("clr_bcount2", 32'(bcount), 32'h00);

    // jump from 3 to 17 is not a step
    hot(3); hot(4); hot(3); hot(17); hot(17);
    chk("jump_bounce", 32'(bounce), 32'h0);
    hot(16); hot(17); hot(17);
    chk("after_jump", 32'(bcount), 32'h01);

    // async reset in the middle of a sweep
    for (int k = 0; k < 8; k++) hot(k);
    #3 R = 1'b0;
    #1 model_reset();
    check_all();
    #1 R = 1'b1;

    // random walk with occasional jumps, garbage and clr
    rp = 0;
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      rc = 0;
      if (r < 80) begin
        if (rp == 0) rp = 1;
        else if (rp == W - 1) rp = W - 2;
        else rp = ($urandom_range(0, 1) == 1) ? rp + 1 : rp - 1;
        rv = W'(1) << rp;
      end else if (r < 88) begin
        rp = int'($urandom_range(0, W - 1));
        rv = W'(1) << rp;
      end else if (r < 97) begin
        rv = W'($urandom);
      end else begin
        rv = W'(1) << rp;
        rc = 1;
      end
      tick(rv, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
